// File: rtl/floo_axis_vc_pkg.sv
// Shared types for the credit-based VC NoC-to-AXIS bridge (tx and rx halves).
package floo_axis_vc_pkg;

    typedef enum logic {
        CH_RSP = 1'b0,
        CH_REQ = 1'b1
    } channel_hdr_e;

    function automatic int unsigned credit_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned DefaultNumCredits = 8;
    localparam int unsigned DefaultCreditWidth = credit_width(DefaultNumCredits);

    typedef struct packed {
        logic                          data_validity;
        channel_hdr_e                  credits_hdr;
        logic [DefaultCreditWidth-1:0] credits;
    } user_bits_t;

endpackage

// File: rtl/floo_vc_credit_counter.sv
// Saturating per-channel credit counter with overflow check.
module floo_vc_credit_counter #(
    parameter int unsigned NumCredits = 8,
    parameter int unsigned CreditWidth = 4,
    parameter logic [CreditWidth-1:0] ResetVal = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [CreditWidth-1:0] inc_i,
    input  logic [CreditWidth-1:0] dec_i,
    output logic [CreditWidth-1:0] cnt_o
);

    localparam logic [CreditWidth:0] MaxCnt = (CreditWidth+1)'(NumCredits);

    logic [CreditWidth:0]   sum;
    logic [CreditWidth:0]   diff;
    logic [CreditWidth-1:0] cnt_d;
    logic                   overflow;

    always_comb begin
        sum = {1'b0, cnt_o} + {1'b0, inc_i};
        diff = (sum > {1'b0, dec_i}) ? sum - {1'b0, dec_i} : '0;
        overflow = diff > MaxCnt;
        cnt_d = overflow ? MaxCnt[CreditWidth-1:0] : diff[CreditWidth-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= ResetVal;
        end else begin
            cnt_o <= cnt_d;
        end
    end

    // A remote returning more than it was given is a protocol bug; clamp and flag it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!overflow)
            else $warning("credit counter overflow, value clamped");
        end
    end

endmodule

// File: rtl/floo_axis_vc_credit_tx.sv
// Transmit half of the credit-based VC bridge: arbitrates req/rsp flits onto
// AXIS and piggybacks locally freed credits in tuser.
module floo_axis_vc_credit_tx
    import floo_axis_vc_pkg::*;
#(
    parameter int unsigned FlitDataSize = 64,
    parameter int unsigned NumCredits = 8,
    parameter int unsigned CreditWidth = credit_width(NumCredits)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FlitDataSize-1:0] req_data_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [FlitDataSize-1:0] rsp_data_i,
    input  logic                    rsp_valid_i,
    output logic                    rsp_ready_o,
    input  logic                    credit_ret_valid_i,
    input  logic                    credit_ret_hdr_i,
    input  logic [CreditWidth-1:0]  credit_ret_cnt_i,
    input  logic                    local_free_req_i,
    input  logic                    local_free_rsp_i,
    output logic [FlitDataSize:0]   axis_tdata_o,
    output logic [CreditWidth+1:0]  axis_tuser_o,
    output logic                    axis_tvalid_o,
    input  logic                    axis_tready_i
);

    // Index 1 is the request channel, index 0 the response channel.
    logic [1:0][CreditWidth-1:0] tx_credit;
    logic [1:0][CreditWidth-1:0] ret_pend;
    logic [1:0]                  valid;
    logic [1:0]                  free;
    logic [1:0]                  elig;
    logic [1:0]                  pend;
    logic [1:0]                  grant;
    logic [1:0]                  sent;
    logic                        load;
    logic                        data_ptr;
    logic                        credit_ptr;
    logic [CreditWidth-1:0]      credits;
    logic [FlitDataSize-1:0]     payload;
    channel_hdr_e                data_hdr;
    channel_hdr_e                credit_hdr;

    assign valid = {req_valid_i, rsp_valid_i};
    assign free = {local_free_req_i, local_free_rsp_i};
    assign load = !axis_tvalid_o || axis_tready_i;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            elig[c] = valid[c] && (tx_credit[c] != '0);
            pend[c] = ret_pend[c] != '0;
        end
    end

    always_comb begin
        grant = '0;
        if (load && !rst_i) begin
            unique case (elig)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = data_ptr ? 2'b10 : 2'b01;
                default: grant = '0;
            endcase
        end
    end

    always_comb begin
        sent = '0;
        if (load && !rst_i) begin
            unique case (pend)
                2'b01:   sent = 2'b01;
                2'b10:   sent = 2'b10;
                2'b11:   sent = credit_ptr ? 2'b10 : 2'b01;
                default: sent = '0;
            endcase
        end
    end

    assign req_ready_o = grant[1];
    assign rsp_ready_o = grant[0];

    assign data_hdr = grant[1] ? CH_REQ : CH_RSP;
    assign credit_hdr = sent[1] ? CH_REQ : CH_RSP;
    assign payload = grant[1] ? req_data_i : rsp_data_i;

    always_comb begin
        credits = '0;
        if (sent[1]) begin
            credits = ret_pend[1];
        end else if (sent[0]) begin
            credits = ret_pend[0];
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [CreditWidth-1:0] ret_inc;
        logic [CreditWidth-1:0] pend_dec;

        assign ret_inc = (credit_ret_valid_i && (credit_ret_hdr_i == 1'(c)))
                       ? credit_ret_cnt_i : '0;
        assign pend_dec = sent[c] ? ret_pend[c] : '0;

        floo_vc_credit_counter #(
            .NumCredits  (NumCredits),
            .CreditWidth (CreditWidth),
            .ResetVal    (CreditWidth'(NumCredits))
        ) i_tx_credit (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc_i (ret_inc),
            .dec_i (CreditWidth'(grant[c])),
            .cnt_o (tx_credit[c])
        );

        floo_vc_credit_counter #(
            .NumCredits  (NumCredits),
            .CreditWidth (CreditWidth),
            .ResetVal    ('0)
        ) i_ret_pend (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc_i (CreditWidth'(free[c])),
            .dec_i (pend_dec),
            .cnt_o (ret_pend[c])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            axis_tvalid_o <= 1'b0;
            axis_tdata_o <= '0;
            axis_tuser_o <= '0;
            data_ptr <= 1'b1;
            credit_ptr <= 1'b1;
        end else if (load) begin
            // Pointers only move when both channels compete.
            if (elig == 2'b11) begin
                data_ptr <= ~data_ptr;
            end
            if (pend == 2'b11) begin
                credit_ptr <= ~credit_ptr;
            end
            axis_tvalid_o <= (|grant) || (|sent);
            axis_tdata_o <= (|grant) ? {data_hdr, payload} : '0;
            axis_tuser_o <= {(|grant), credit_hdr, credits};
        end
    end

endmodule

// File: tb/tb_floo_axis_vc_credit_tx.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural credit/arbitration model.
module tb_floo_axis_vc_credit_tx;
    import floo_axis_vc_pkg::*;

    localparam int W = 64;
    localparam int N = 8;
    localparam int CW = credit_width(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  req_data = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [W-1:0]  rsp_data = '0;
    logic          rsp_valid = 1'b0;
    logic          rsp_ready;
    logic          ret_valid = 1'b0;
    logic          ret_hdr = 1'b0;
    logic [CW-1:0] ret_cnt = '0;
    logic          free_req = 1'b0;
    logic          free_rsp = 1'b0;
    logic [W:0]    tdata;
    logic [CW+1:0] tuser;
    logic          tvalid;
    logic          tready = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    floo_axis_vc_credit_tx #(
        .FlitDataSize (W),
        .NumCredits   (N)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_data_i         (req_data),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .rsp_data_i         (rsp_data),
        .rsp_valid_i        (rsp_valid),
        .rsp_ready_o        (rsp_ready),
        .credit_ret_valid_i (ret_valid),
        .credit_ret_hdr_i   (ret_hdr),
        .credit_ret_cnt_i   (ret_cnt),
        .local_free_req_i   (free_req),
        .local_free_rsp_i   (free_rsp),
        .axis_tdata_o       (tdata),
        .axis_tuser_o       (tuser),
        .axis_tvalid_o      (tvalid),
        .axis_tready_i      (tready)
    );

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: credits remaining, credits owed, fairness state and
    // the beat that must currently sit on the link.
    int            txc[2];
    int            rp[2];
    bit            dptr;
    bit            cptr;
    bit            m_valid;
    logic [W:0]    m_data;
    logic [CW+1:0] m_user;
    bit            model_ok = 1'b0;

    always @(negedge clk) begin
        int g;
        int s;
        int ret;
        bit load;
        bit e0;
        bit e1;
        bit p0;
        bit p1;
        int fr[2];
        logic [CW-1:0] cr;
        if (model_ok) begin
            check("tvalid", tvalid, m_valid);
            if (m_valid) begin
                check("tdata", tdata, m_data);
                check("tuser", tuser, m_user);
            end
        end
        if (rst) begin
            if (model_ok) begin
                check("ready_in_reset", {req_ready, rsp_ready}, 2'b00);
            end
            txc[0] = N;
            txc[1] = N;
            rp[0] = 0;
            rp[1] = 0;
            dptr = 1'b1;
            cptr = 1'b1;
            m_valid = 1'b0;
            m_data = '0;
            m_user = '0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            load = !m_valid || tready;
            g = -1;
            s = -1;
            if (load) begin
                e1 = req_valid && txc[1] > 0;
                e0 = rsp_valid && txc[0] > 0;
                if (e1 && e0) begin
                    g = dptr ? 1 : 0;
                    dptr = !dptr;
                end else if (e1) begin
                    g = 1;
                end else if (e0) begin
                    g = 0;
                end
                p1 = rp[1] > 0;
                p0 = rp[0] > 0;
                if (p1 && p0) begin
                    s = cptr ? 1 : 0;
                    cptr = !cptr;
                end else if (p1) begin
                    s = 1;
                end else if (p0) begin
                    s = 0;
                end
            end
            check("req_ready", req_ready, g == 1);
            check("rsp_ready", rsp_ready, g == 0);
            if (load) begin
                cr = '0;
                if (s >= 0) begin
                    cr = CW'(rp[s]);
                end
                m_valid = (g >= 0) || (s >= 0);
                if (g == 1) begin
                    m_data = {1'b1, req_data};
                end else if (g == 0) begin
                    m_data = {1'b0, rsp_data};
                end else begin
                    m_data = '0;
                end
                m_user = {g >= 0, s == 1, cr};
            end
            fr[0] = int'(free_rsp);
            fr[1] = int'(free_req);
            for (int c = 0; c < 2; c++) begin
                ret = (ret_valid && ret_hdr == 1'(c)) ? int'(ret_cnt) : 0;
                txc[c] = txc[c] - ((g == c) ? 1 : 0) + ret;
                if (txc[c] > N) txc[c] = N;
                rp[c] = rp[c] + fr[c] - ((s == c) ? rp[c] : 0);
                if (rp[c] > N) rp[c] = N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        rsp_valid = 1'b0;
        ret_valid = 1'b0;
        free_req = 1'b0;
        free_rsp = 1'b0;
    endtask

    initial begin
        int n;
        idle();
        tick();
        tick();
        rst = 1'b0;
        tready = 1'b1;

        @(negedge clk);
        check("reset_out", {tvalid, tuser, tdata}, '0);
        tick();

        // Eight back-to-back requests drain the request credits.
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_data = 64'(100 + i);
            @(negedge clk);
            check("burst_ready", req_ready, 1'b1);
            if (i == 0) begin
                check("burst_first_empty", tvalid, 1'b0);
            end else begin
                check("burst_beat", {tvalid, tuser[CW+1], tdata},
                      {1'b1, 1'b1, 1'b1, 64'(100 + i - 1)});
            end
            tick();
        end
        rsp_valid = 1'b1;
        rsp_data = 64'hAA;
        req_data = 64'd999;
        @(negedge clk);
        check("ninth_req_blocked", req_ready, 1'b0);
        check("rsp_passes", rsp_ready, 1'b1);
        check("beat8", tdata, {1'b1, 64'd107});
        tick();
        idle();
        @(negedge clk);
        check("rsp_beat", {tuser[CW+1], tdata}, {1'b1, 1'b0, 64'hAA});
        tick();

        // Refill both channels.
        ret_valid = 1'b1;
        ret_hdr = 1'b1;
        ret_cnt = CW'(8);
        tick();
        ret_hdr = 1'b0;
        ret_cnt = CW'(1);
        tick();
        idle();

        // Contention alternates, request first.
        req_valid = 1'b1;
        rsp_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) idle();
            req_data = 64'(200 + i);
            rsp_data = 64'(300 + i);
            @(negedge clk);
            if (i < 8) check("alt_ready", req_ready, (i % 2) == 0);
            if (i > 0) check("alt_hdr", tdata[W], ((i - 1) % 2) == 0);
            tick();
        end

        // Stall with a beat held.
        req_valid = 1'b1;
        req_data = 64'h5151;
        tick();
        idle();
        req_valid = 1'b1;
        rsp_valid = 1'b1;
        tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", tvalid, 1'b1);
            check("stall_data", tdata, {1'b1, 64'h5151});
            check("stall_ready", {req_ready, rsp_ready}, 2'b00);
            tick();
        end
        idle();
        tready = 1'b1;
        tick();
        tick();

        // Freed response entries accumulate behind a stalled beat.
        req_valid = 1'b1;
        req_data = 64'h77;
        tick();
        idle();
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            free_rsp = 1'b1;
            tick();
        end
        free_rsp = 1'b0;
        tready = 1'b1;
        tick();
        @(negedge clk);
        check("credit_only", {tvalid, tuser, tdata}, {1'b1, 6'b000011, 65'd0});
        tick();
        @(negedge clk);
        check("credit_drained", tvalid, 1'b0);
        tick();

        // Exhaust request credits, then return two.
        req_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!req_ready) break;
            n++;
            tick();
        end
        check("exhaust_count", n, 2);
        ret_valid = 1'b1;
        ret_hdr = 1'b1;
        ret_cnt = CW'(2);
        #1;
        check("same_cycle_return", req_ready, 1'b0);
        tick();
        ret_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (req_ready) n++;
            tick();
        end
        check("return_count", n, 2);

        // Over-return clamps at the buffer depth.
        idle();
        ret_valid = 1'b1;
        ret_hdr = 1'b1;
        ret_cnt = CW'(8);
        tick();
        ret_cnt = CW'(1);
        tick();
        idle();
        req_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready) n++;
            tick();
        end
        check("clamp_count", n, 8);

        // Reset while stalled.
        idle();
        rsp_valid = 1'b1;
        rsp_data = 64'h33;
        tick();
        idle();
        tready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tready = 1'b1;
        @(negedge clk);
        check("reset_discard", tvalid, 1'b0);
        tick();
        req_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready) n++;
            tick();
        end
        check("reset_restores", n, 8);

        // Randomized traffic with legal credit returns.
        idle();
        for (int i = 0; i < 3000; i++) begin
            int room;
            rst = ($urandom % 600) == 0;
            req_valid = $urandom % 2;
            rsp_valid = $urandom % 2;
            req_data = {$urandom, $urandom};
            rsp_data = {$urandom, $urandom};
            tready = ($urandom % 4) != 0;
            ret_hdr = $urandom % 2;
            room = N - txc[ret_hdr];
            ret_valid = (($urandom % 3) == 0) && room > 0;
            ret_cnt = ret_valid ? CW'($urandom_range(1, room)) : '0;
            free_req = (($urandom % 3) == 0) && rp[1] < N;
            free_rsp = (($urandom % 3) == 0) && rp[0] < N;
            tick();
        end
        idle();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
